// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and sizes.
// Used by the register file and its read-port helper.
package mips_pkg;
    localparam int REG_W     = 32;
    localparam int REG_N     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_W-1:0]     word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/gpr_if.sv
// Register-file port bundle: two read indices, one write port and the shamt override.
// WriteEnable is a plain strobe; there is no valid/ready, and a write happens on every enabled edge.
interface gpr_if;
    import mips_pkg::*;

    reg_idx_t RegWrite;
    reg_idx_t RegA;
    reg_idx_t RegB;
    logic     WriteEnable;
    word_t    WriteData;
    reg_idx_t shamt;
    word_t    BusA;
    word_t    BusB;

    modport master (
        output RegWrite, RegA, RegB, WriteEnable, WriteData, shamt,
        input  BusA, BusB
    );

    modport slave (
        input  RegWrite, RegA, RegB, WriteEnable, WriteData, shamt,
        output BusA, BusB
    );
endinterface

// File: rtl/gpr_read_port.sv
// One combinational read port; index 0 always reads zero regardless of storage.
module gpr_read_port
    import mips_pkg::*;
(
    input  word_t    regs_i [REG_N],
    input  reg_idx_t idx_i,
    output word_t    data_o
);
    assign data_o = (idx_i == '0) ? '0 : regs_i[idx_i];
endmodule

// File: rtl/gpr.sv
// 32x32 MIPS register file: two combinational reads, one synchronous write,
// with shamt overriding port A so shift instructions feed the ALU directly.
module gpr
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    gpr_if.slave  bus
);
    word_t regs_q [REG_N];
    word_t regs_d [REG_N];
    word_t port_a;
    word_t port_b;

    always_comb begin
        regs_d = regs_q;
        if (bus.WriteEnable && (bus.RegWrite != '0)) begin
            regs_d[bus.RegWrite] = bus.WriteData;
        end
    end

    // Reset wins over a same-edge write, so the pending write is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    gpr_read_port u_port_a (
        .regs_i (regs_q),
        .idx_i  (bus.RegA),
        .data_o (port_a)
    );

    gpr_read_port u_port_b (
        .regs_i (regs_q),
        .idx_i  (bus.RegB),
        .data_o (port_b)
    );

    assign bus.BusA = (bus.shamt != '0) ? {{(REG_W-REG_IDX_W){1'b0}}, bus.shamt} : port_a;
    assign bus.BusB = port_b;
endmodule

// File: tb/tb_gpr.sv
// Directed bench for the gpr register file with hand-computed expectations.
module tb_gpr;
    import mips_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    gpr_if bus ();

    gpr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [4:0] idx, input logic [31:0] data, input logic we);
        bus.RegWrite    = idx;
        bus.WriteData   = data;
        bus.WriteEnable = we;
    endtask

    task automatic drive_read(input logic [4:0] a, input logic [4:0] b, input logic [4:0] sh);
        bus.RegA  = a;
        bus.RegB  = b;
        bus.shamt = sh;
    endtask

    initial begin
        logic [31:0] exp_v;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive_write(5'd0, 32'h0, 1'b0);
        drive_read(5'd3, 5'd4, 5'd0);
        tick();
        reset = 1'b0;
        #1;
        check("reset_busa", bus.BusA, 32'h0);
        check("reset_busb", bus.BusB, 32'h0);

        // Write r4 = 5; old value visible until the edge.
        drive_write(5'd4, 32'd5, 1'b1);
        drive_read(5'd4, 5'd4, 5'd0);
        #1;
        check("pre_write_busb", bus.BusB, 32'h0);
        tick();
        check("post_write_busb", bus.BusB, 32'd5);
        check("post_write_busa_same", bus.BusA, 32'd5);

        // Writes to r0 are discarded.
        drive_write(5'd0, 32'd5, 1'b1);
        drive_read(5'd0, 5'd4, 5'd0);
        tick();
        check("zero_reg_busa", bus.BusA, 32'h0);

        // shamt override on port A.
        drive_write(5'd0, 32'd0, 1'b0);
        drive_read(5'd0, 5'd4, 5'd1);
        #1;
        check("shamt1_busa", bus.BusA, 32'h1);
        drive_read(5'd4, 5'd4, 5'd31);
        #1;
        check("shamt31_busa", bus.BusA, 32'h0000001F);
        check("shamt31_busb", bus.BusB, 32'd5);

        // WriteEnable low leaves r7 unchanged.
        drive_write(5'd7, 32'hDEADBEEF, 1'b0);
        drive_read(5'd7, 5'd7, 5'd0);
        tick();
        check("we_low_busa", bus.BusA, 32'h0);
        check("we_low_busb", bus.BusB, 32'h0);

        // Mid-cycle reset with a pending write to r4.
        drive_write(5'd4, 32'd9, 1'b1);
        drive_read(5'd4, 5'd4, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_before_edge", bus.BusB, 32'd5);
        tick();
        check("reset_beats_write_b", bus.BusB, 32'h0);
        check("reset_beats_write_a", bus.BusA, 32'h0);
        drive_read(5'd4, 5'd4, 5'd6);
        #1;
        check("reset_shamt_busa", bus.BusA, 32'd6);
        reset = 1'b0;
        drive_write(5'd0, 32'd0, 1'b0);

        // Full sweep: write i*0x01010101 to every register.
        for (int i = 1; i < REG_N; i++) begin
            drive_write(i[4:0], i * 32'h01010101, 1'b1);
            tick();
        end
        drive_write(5'd0, 32'd0, 1'b0);
        for (int i = 0; i < REG_N; i++) begin
            drive_read(i[4:0], i[4:0], 5'd0);
            #1;
            exp_v = (i == 0) ? 32'h0 : i * 32'h01010101;
            check($sformatf("sweep_a_r%0d", i), bus.BusA, exp_v);
            check($sformatf("sweep_b_r%0d", i), bus.BusB, exp_v);
        end

        // Distinct registers on the two ports at once.
        drive_read(5'd31, 5'd17, 5'd0);
        #1;
        check("mixed_busa_r31", bus.BusA, 32'h1F1F1F1F);
        check("mixed_busb_r17", bus.BusB, 32'h11111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
